dac_ad53xx: RTL and testbench



---
 rtl/dac_ad53xx_pkg.sv | 14 +
 rtl/dac_serial_rx.sv | 55 +++++
 rtl/dac_ad53xx.sv | 76 +++++++
 tb/tb_dac_ad53xx.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/dac_ad53xx_pkg.sv
// dac_ad53xx_pkg: frame layout, control/LDAC/receiver enums shared by the DAC model
package dac_ad53xx_pkg;
  localparam int FRAME_W    = 16;
  localparam int F_TYPE     = 15;
  localparam int F_ADDR_HI  = 14;
  localparam int F_ADDR_LO  = 12;
  localparam int F_DATA_HI  = 11;
  localparam int F_CTYPE_HI = 14;
  localparam int F_CTYPE_LO = 13;
  localparam int F_FULL_RST = 12;
  typedef enum logic [1:0] {CTRL_FUNC, LDAC_CTRL, POWER_DOWN, RESET} ctrl_type_e;
  typedef enum logic [1:0] {LDAC_CONT, LDAC_HOLD, LDAC_ONESHOT} ldac_mode_e;
  typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_WAIT_HI} rx_state_e;
endpackage

// File: rtl/dac_serial_rx.sv
// dac_serial_rx: SYNC_b-gated 16-bit MSB-first receiver with short/long frame detection
module dac_serial_rx
  import dac_ad53xx_pkg::*;
(
  input  logic               SCLK,
  input  logic               RST_b,
  input  logic               SYNC_b,
  input  logic               DIN,
  output logic               frame_valid,
  output logic [FRAME_W-1:0] frame,
  output logic               FRAME_ERR
);
  rx_state_e state;
  logic [FRAME_W-2:0] sr;
  logic [3:0] cnt;
  logic err_done;
  assign frame_valid = state == RX_SHIFT && !SYNC_b && cnt == 4'd15;
  assign frame = {sr, DIN};
  // receiver FSM: shift bits while SYNC_b low, flag frames that end early or run past 16 bits
  always_ff @(posedge SCLK or negedge RST_b) begin
    if (!RST_b) begin
      state     <= RX_IDLE;
      sr        <= '0;
      cnt       <= '0;
      err_done  <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      FRAME_ERR <= 1'b0;
      case (state)
        RX_IDLE: if (!SYNC_b) begin
          state <= RX_SHIFT;
          sr    <= {{(FRAME_W-2){1'b0}}, DIN};
          cnt   <= 4'd1;
        end
        RX_SHIFT: if (SYNC_b) begin
          state     <= RX_IDLE;
          FRAME_ERR <= 1'b1;
        end else begin
          sr  <= {sr[FRAME_W-3:0], DIN};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state    <= RX_WAIT_HI;
            err_done <= 1'b0;
          end
        end
        RX_WAIT_HI: if (SYNC_b) state <= RX_IDLE;
          else if (!err_done) begin
            FRAME_ERR <= 1'b1;
            err_done  <= 1'b1;
          end
        default: state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/dac_ad53xx.sv
// dac_ad53xx: behavioural AD5308/18/28 multi-channel serial DAC with LDAC and power-down
module dac_ad53xx
  import dac_ad53xx_pkg::*;
#(
  parameter int N_CH   = 8,
  parameter int DATA_W = 10,
  parameter bit PD_Z   = 1'b1
) (
  input  logic                           SCLK,
  input  logic                           RST_b,
  input  logic                           SYNC_b,
  input  logic                           DIN,
  input  logic                           LDAC_b,
  output logic [N_CH-1:0][DATA_W-1:0]    VOUT,
  output logic [5:0]                     CTRL,
  output logic                           FRAME_ERR
);
  logic frame_valid;
  logic [FRAME_W-1:0] frame;
  logic [N_CH-1:0][DATA_W-1:0] inreg, dacreg;
  logic [N_CH-1:0] pd;
  ldac_mode_e mode;
  logic ldac_q, load;
  logic [2:0] addr;
  logic [DATA_W-1:0] data;
  ctrl_type_e ctype;
  dac_serial_rx u_rx (
    .SCLK        (SCLK),
    .RST_b       (RST_b),
    .SYNC_b      (SYNC_b),
    .DIN         (DIN),
    .frame_valid (frame_valid),
    .frame       (frame),
    .FRAME_ERR   (FRAME_ERR)
  );
  assign addr  = frame[F_ADDR_HI:F_ADDR_LO];
  assign data  = frame[F_DATA_HI -: DATA_W];
  assign ctype = ctrl_type_e'(frame[F_CTYPE_HI:F_CTYPE_LO]);
  assign load  = mode != LDAC_HOLD || !ldac_q;
  // register file: LDAC loads first, a decoded frame on the same edge overrides it
  always_ff @(posedge SCLK or negedge RST_b) begin
    if (!RST_b) begin
      inreg  <= '0;
      dacreg <= '0;
      CTRL   <= '0;
      mode   <= LDAC_HOLD;
      pd     <= '1;
      ldac_q <= 1'b1;
    end else begin
      ldac_q <= LDAC_b;
      if (load) dacreg <= inreg;
      if (mode == LDAC_ONESHOT) mode <= LDAC_HOLD;
      if (frame_valid && !frame[F_TYPE])
        for (int c = 0; c < N_CH; c++)
          if (addr == 3'(c)) inreg[c] <= data;
      if (frame_valid && frame[F_TYPE])
        case (ctype)
          CTRL_FUNC:  CTRL <= frame[5:0];
          LDAC_CTRL:  if (frame[1:0] != 2'b11) mode <= ldac_mode_e'(frame[1:0]);
          POWER_DOWN: pd <= frame[N_CH-1:0];
          RESET: begin
            inreg  <= '0;
            dacreg <= '0;
            if (frame[F_FULL_RST]) begin
              CTRL <= '0;
              mode <= LDAC_HOLD;
              pd   <= '1;
            end
          end
        endcase
    end
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_out
    assign VOUT[i] = !pd[i] ? dacreg[i] : (PD_Z ? {DATA_W{1'bz}} : {DATA_W{1'b0}});
  end
endmodule

// File: tb/tb_dac_ad53xx.sv
// tb_dac_ad53xx: scoreboard bench for the serial DAC model (powered-down value driven as zero)
module tb_dac_ad53xx;
  localparam int N_CH = 8;
  localparam int DATA_W = 10;
  logic SCLK = 1'b0, RST_b = 1'b0, SYNC_b = 1'b1, DIN = 1'b0, LDAC_b = 1'b1;
  logic [N_CH-1:0][DATA_W-1:0] vout;
  logic [5:0] ctrl;
  logic frame_err;
  int n_chk = 0, n_err = 0, n_fe = 0, fe0;
  typedef struct {string tag; int ch; logic [DATA_W-1:0] val;} exp_t;
  exp_t sb[$];
  dac_ad53xx #(.N_CH(N_CH), .DATA_W(DATA_W), .PD_Z(1'b0)) dut (
    .SCLK      (SCLK),
    .RST_b     (RST_b),
    .SYNC_b    (SYNC_b),
    .DIN       (DIN),
    .LDAC_b    (LDAC_b),
    .VOUT      (vout),
    .CTRL      (ctrl),
    .FRAME_ERR (frame_err)
  );
  always #5 SCLK = ~SCLK;
  always @(negedge SCLK) if (frame_err) n_fe++;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic expv(input string tag, input int ch, input logic [DATA_W-1:0] val);
    sb.push_back('{tag, ch, val});
  endtask
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, 16'(vout[e.ch]), 16'(e.val));
    end
  endtask
  task automatic shift_bits(input logic [15:0] w, input int n);
    logic [15:0] s;
    s = w;
    for (int i = 0; i < n; i++) begin
      @(negedge SCLK);
      SYNC_b = 1'b0;
      DIN = s[15];
      s = s << 1;
    end
  endtask
  task automatic send(input logic [15:0] w, input int n = 16);
    shift_bits(w, n);
    @(negedge SCLK);
    SYNC_b = 1'b1;
    DIN = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge SCLK);
  endtask
  task automatic ldac_pulse();
    @(negedge SCLK) LDAC_b = 1'b0;
    @(negedge SCLK) LDAC_b = 1'b1;
    @(negedge SCLK);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    idle(3);
    #1;
    for (int c = 0; c < N_CH; c++) expv("rst_vout", c, '0);
    drain();
    check("rst_ctrl", 16'(ctrl), 16'h0);
    check("rst_ferr", 16'(frame_err), 16'h0);
    @(negedge SCLK) RST_b = 1'b1;
    send(16'hC000);
    send(16'hA000);
    send(16'h1ABC);
    expv("cont_same_edge", 1, '0);
    drain();
    idle(1);
    expv("cont_next_edge", 1, 10'h2AF);
    drain();
    send(16'h802D);
    check("ctrl_write", 16'(ctrl), 16'h002D);
    send(16'hA001);
    send(16'h3FFC);
    idle(3);
    expv("hold_no_ldac", 3, '0);
    drain();
    @(negedge SCLK) LDAC_b = 1'b0;
    @(negedge SCLK) LDAC_b = 1'b1;
    expv("hold_ldac_sampled", 3, '0);
    drain();
    @(negedge SCLK);
    expv("hold_loaded", 3, 10'h3FF);
    expv("hold_ch1_kept", 1, 10'h2AF);
    drain();
    send(16'h5155);
    idle(2);
    expv("os_pre", 5, '0);
    drain();
    send(16'hA002);
    expv("os_decode_edge", 5, '0);
    drain();
    idle(1);
    expv("os_loaded", 5, 10'h055);
    drain();
    send(16'h5200);
    idle(3);
    expv("os_back_to_hold", 5, 10'h055);
    drain();
    fe0 = n_fe;
    send(16'h7FFC, 9);
    idle(2);
    check("short_ferr", 16'(n_fe - fe0), 16'd1);
    ldac_pulse();
    expv("short_no_write", 7, '0);
    expv("short_ldac_ch5", 5, 10'h080);
    drain();
    fe0 = n_fe;
    send(16'h6ABC, 18);
    idle(2);
    check("long_ferr", 16'(n_fe - fe0), 16'd1);
    ldac_pulse();
    expv("long_decoded", 6, 10'h2AF);
    drain();
    send(16'hA000);
    send(16'hE000);
    expv("clr_ch1", 1, '0);
    expv("clr_ch3", 3, '0);
    expv("clr_ch6", 6, '0);
    drain();
    check("clr_ctrl_kept", 16'(ctrl), 16'h002D);
    send(16'hF000);
    check("full_rst_ctrl", 16'(ctrl), 16'h0);
    send(16'h1ABC);
    ldac_pulse();
    expv("full_rst_pd", 1, '0);
    drain();
    send(16'hC000);
    expv("full_rst_hold_loaded", 1, 10'h2AF);
    drain();
    fe0 = n_fe;
    shift_bits(16'h2ABC, 8);
    @(negedge SCLK);
    RST_b = 1'b0;
    SYNC_b = 1'b1;
    #1;
    check("abort_ferr", 16'(frame_err), 16'h0);
    @(negedge SCLK) RST_b = 1'b1;
    idle(2);
    check("abort_no_err", 16'(n_fe - fe0), 16'd0);
    send(16'hC000);
    send(16'hA000);
    send(16'h2ABC);
    idle(1);
    expv("abort_clean_frame", 2, 10'h2AF);
    expv("abort_ch1_cleared", 1, '0);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
